conv_out_collector: RTL and testbench

CONV_OUT_COLLECTOR -- requirements
Module: conv_out_collector

---
 rtl/conv_out_collector.sv | 149 ++++++++++++++
 tb/tb_conv_out_collector.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_out_collector.sv
// Collects conv output beats into a FWFT buffer and streams them to DMA with tlast/done framing.
// Optional macro OUT_COLLECTOR_STATS_EN adds a saturating stall counter on the DMA stream.
module conv_out_collector #(
  parameter int FIFO_DEPTH     = 512,
  parameter int BEAT_CNT_WIDTH = 24
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [BEAT_CNT_WIDTH-1:0]       cfg_num_beats,
  input  logic                            start,
  input  logic [63:0]                     in_data,
  input  logic                            in_valid,
  output logic [63:0]                     m_tdata,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  output logic                            m_tlast,
  output logic                            busy,
  output logic                            done,
  output logic                            overflow,
  output logic [$clog2(FIFO_DEPTH):0]     fill_level,
  output logic [31:0]                     stall_cycles
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = AW + 1;
  localparam logic [BEAT_CNT_WIDTH-1:0] ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                    r_state;
  logic [BEAT_CNT_WIDTH-1:0] r_total, r_acc_cnt, r_emit_cnt;
  logic                      r_busy, r_done, r_ovf;

  logic [63:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [FW-1:0] r_fill;
  logic          r_tvalid;
  logic [63:0]   r_tdata;

  logic          w_run, w_pop, w_in_range, w_full, w_push, w_drop, w_load, w_last;
  logic [FW-1:0] w_mem_cnt;

  assign w_run      = (r_state == S_RUN);
  assign w_pop      = r_tvalid && m_tready;
  assign w_in_range = w_run && in_valid && (r_acc_cnt < r_total);
  assign w_full     = (r_fill == FW'(FIFO_DEPTH));
  assign w_push     = w_in_range && (!w_full || w_pop);
  assign w_drop     = w_in_range && w_full && !w_pop;
  // The output register counts toward occupancy; memory holds the rest.
  assign w_mem_cnt  = r_fill - FW'(r_tvalid);
  assign w_load     = (w_mem_cnt != '0) && (!r_tvalid || w_pop);
  assign w_last     = r_tvalid && (r_emit_cnt == r_total - ONE);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_load) begin
        r_tdata  <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_tvalid <= 1'b1;
      end else if (w_pop) begin
        r_tvalid <= 1'b0;
      end
      r_fill <= r_fill + FW'(w_push) - FW'(w_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_total    <= '0;
      r_acc_cnt  <= '0;
      r_emit_cnt <= '0;
      r_ovf      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_total    <= cfg_num_beats;
            r_acc_cnt  <= '0;
            r_emit_cnt <= '0;
            r_ovf      <= 1'b0;
            r_busy     <= 1'b1;
            if (cfg_num_beats == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (w_in_range) r_acc_cnt <= r_acc_cnt + ONE;
          // Drops advance the emitted count so tlast lands on the last buffered beat.
          if (w_pop || w_drop) r_emit_cnt <= r_emit_cnt + ONE;
          if (w_drop) r_ovf <= 1'b1;
          if (w_pop && w_last) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef OUT_COLLECTOR_STATS_EN
  logic [31:0] r_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stall <= '0;
    else if (r_state == S_IDLE && start)
      r_stall <= '0;
    else if (r_tvalid && !m_tready && r_stall != '1)
      r_stall <= r_stall + 32'd1;
  end

  assign stall_cycles = r_stall;
`else
  assign stall_cycles = '0;
`endif

  assign m_tdata    = r_tdata;
  assign m_tvalid   = r_tvalid;
  assign m_tlast    = w_last;
  assign busy       = r_busy;
  assign done       = r_done;
  assign overflow   = r_ovf;
  assign fill_level = r_fill;

endmodule

// File: tb/tb_conv_out_collector.sv
// Randomized scoreboard bench for conv_out_collector against a queue-level reference model.
module tb_conv_out_collector;
  localparam int DEPTH = 4;
  localparam int BCW   = 24;
  localparam int FLW   = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [BCW-1:0]   cfg_num_beats = '0;
  logic             start = 1'b0;
  logic [63:0]      in_data = '0;
  logic             in_valid = 1'b0;
  logic             m_tready = 1'b0;
  logic [63:0]      m_tdata;
  logic             m_tvalid, m_tlast, busy, done, overflow;
  logic [FLW-1:0]   fill_level;
  logic [31:0]      stall_cycles;

  always #5 clk = ~clk;

  conv_out_collector #(.FIFO_DEPTH(DEPTH), .BEAT_CNT_WIDTH(BCW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_num_beats(cfg_num_beats), .start(start),
    .in_data(in_data), .in_valid(in_valid), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tlast(m_tlast), .busy(busy), .done(done),
    .overflow(overflow), .fill_level(fill_level), .stall_cycles(stall_cycles)
  );

  typedef struct { logic [63:0] d; int avail; } ent_t;
  typedef struct { logic [63:0] d; logic last; } sb_t;

  ent_t   q[$];     // model buffer: data plus first cycle it may be visible at the output
  sb_t    sb[$];    // expected output stream
  int     nvec = 0, nerr = 0, cyc = 0;
  bit     chk_en = 1'b0;
  int     mstate, total, acc, emit;
  bit     ovf;
  longint stall;
  bit     e_tvalid, e_tlast, e_busy, e_done, e_ovf;
  int     e_fill;
  longint e_stall;
  bit     prev_hold;
  logic [63:0] prev_data;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete(); sb.delete();
    mstate = 0; total = 0; acc = 0; emit = 0; ovf = 0; stall = 0;
    e_tvalid = 0; e_tlast = 0; e_busy = 0; e_done = 0; e_ovf = 0; e_fill = 0; e_stall = 0;
  endfunction

  // Predict this cycle's outputs from the current inputs, then advance the model one edge.
  task automatic model_eval();
    bit   pop;
    ent_t e;
    sb_t  s;
    e_tvalid = (q.size() > 0) && (q[0].avail <= cyc);
    e_tlast  = e_tvalid && (emit == total - 1);
    e_busy   = (mstate != 0);
    e_done   = (mstate == 2);
    e_fill   = q.size();
    e_ovf    = ovf;
    e_stall  = stall;
    pop = e_tvalid && m_tready;
`ifdef OUT_COLLECTOR_STATS_EN
    if (e_tvalid && !m_tready && stall < 64'hffff_ffff) stall++;
`endif
    case (mstate)
      0: if (start) begin
        total = int'(cfg_num_beats); acc = 0; emit = 0; ovf = 0; stall = 0;
        mstate = (total == 0) ? 2 : 1;
      end
      1: begin
        if (in_valid && acc < total) begin
          if (q.size() < DEPTH || pop) begin
            e.d = in_data; e.avail = cyc + 2; q.push_back(e);
            s.d = in_data; s.last = 1'b0; sb.push_back(s);
          end else begin
            ovf = 1; emit++;
          end
          acc++;
          if (acc == total && sb.size() > 0) begin
            s = sb.pop_back(); s.last = 1'b1; sb.push_back(s);
          end
        end
        if (pop) begin
          void'(q.pop_front());
          emit++;
          if (e_tlast) mstate = 2;
        end
      end
      default: mstate = 0;
    endcase
  endtask

  task automatic cycle(input bit st, input int cfg, input bit iv, input logic [63:0] d, input bit rdy);
    start = st; cfg_num_beats = cfg[BCW-1:0]; in_valid = iv; in_data = d; m_tready = rdy;
    model_eval();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_tvalid", m_tvalid, 0);   chk("rst_tlast", m_tlast, 0);
    chk("rst_tdata", m_tdata, 0);     chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);         chk("rst_overflow", overflow, 0);
    chk("rst_fill", fill_level, 0);   chk("rst_stall", stall_cycles, 0);
    model_reset();
    prev_hold = 0;
    start = 0; in_valid = 0; m_tready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
    chk_en = 1'b1;
  endtask

  function automatic bit rdy(input int m, input int k, input int rk);
    case (m)
      0:       return 1'b1;
      1:       return (k % 2) == 0;
      2:       return 1'(($urandom_range(1)));
      default: return k >= rk;
    endcase
  endfunction

  task automatic run_pass(input int n, input int nin, input int rmode, input int vpct,
                          input int rk, input bit seqd);
    int sent, k;
    bit iv;
    logic [63:0] d;
    sent = 0; k = 0;
    cycle(1'b1, n, 1'b0, 64'd0, rdy(rmode, 0, rk));
    while (mstate != 0 && k < 600) begin
      iv = (sent < nin) && ($urandom_range(99) < vpct);
      d = seqd ? 64'(sent + 1) * 64'h11 : {$urandom, $urandom};
      if (iv) sent++;
      // stray start pulses while busy must be ignored
      cycle($urandom_range(7) == 0, $urandom_range(20), iv, d, rdy(rmode, k + 1, rk));
      k++;
    end
    if (mstate != 0) begin
      nvec++; nerr++;
      $display("FAIL pass_timeout: got busy after %0d cycles expected idle", k);
      do_reset();
    end
  endtask

  task automatic idle_cycles(input int nc);
    for (int i = 0; i < nc; i++)
      cycle(1'b0, 0, 1'($urandom_range(1)), {$urandom, $urandom}, 1'($urandom_range(1)));
  endtask

  always @(negedge clk) begin
    sb_t s;
    if (chk_en) begin
      chk("tvalid", m_tvalid, e_tvalid);
      chk("tlast", m_tlast, e_tlast);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("overflow", overflow, e_ovf);
      chk("fill_level", fill_level, e_fill);
      chk("stall_cycles", stall_cycles, e_stall);
      if (prev_hold) chk("tdata_stable", m_tdata, prev_data);
      if (m_tvalid && m_tready) begin
        if (sb.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL sb_underflow: got beat %0h expected none", m_tdata);
        end else begin
          s = sb.pop_front();
          chk("tdata", m_tdata, s.d);
          chk("tlast_beat", m_tlast, s.last);
        end
      end
      prev_hold = m_tvalid && !m_tready;
      prev_data = m_tdata;
    end
  end

  initial begin
    #2;
    do_reset();
    idle_cycles(3);
    run_pass(4, 4, 0, 100, 0, 1'b1);
    idle_cycles(2);
    run_pass(0, 0, 0, 100, 0, 1'b1);
    idle_cycles(2);
    run_pass(6, 6, 3, 100, 10, 1'b1);
    idle_cycles(2);
    run_pass(3, 5, 0, 100, 0, 1'b1);
    idle_cycles(2);
    run_pass(8, 8, 1, 100, 0, 1'b1);
    idle_cycles(2);
    cycle(1'b1, 4, 1'b0, 64'd0, 1'b1);
    cycle(1'b0, 0, 1'b1, 64'h11, 1'b1);
    in_valid = 1'b1; in_data = 64'h22;
    #2;
    do_reset();
    run_pass(4, 4, 0, 100, 0, 1'b1);
    for (int p = 0; p < 30; p++) begin
      int n;
      n = $urandom_range(1, 10);
      idle_cycles($urandom_range(0, 3));
      run_pass(n, n + $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(30, 100),
               $urandom_range(0, 15), 1'b0);
    end
    idle_cycles(3);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
